// File: rtl/gated_osc_meter_if.sv
// Bundle of control, status and oscillator-facing signals of gated_osc_meter.
// The master side is the controller user: it requests measurements and
// feeds back the returned oscillator clock.
interface gated_osc_meter_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             cko_in;
  logic             enb;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output start, win_len, cko_in,
    input  enb, busy, done, count, ovf
  );

  modport slave (
    input  start, win_len, cko_in,
    output enb, busy, done, count, ovf
  );
endinterface

// File: rtl/gated_osc_meter.sv
// Gated oscillator measurement controller.
// Opens an enable window of win_len clk cycles on an active-low oscillator
// enable, then counts synchronized rising edges of the returned clock. After
// the window closes, counting continues for DRAIN cycles so that edges still
// in the synchronizer are not lost.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; count/ovf hold the last result
// ST_MEAS  | enb low, window counter running, edges counted
// ST_DRAIN | enb high again, edges still in flight are counted
// ST_DONE  | one-cycle done pulse, result valid
module gated_osc_meter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int DRAIN = 3
) (
  input  logic               clk,
  input  logic               rstb,
  gated_osc_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEAS  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
  localparam logic [WIN_W-1:0] DRAIN_LEN = WIN_W'(DRAIN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             s1_q, s2_q, s3_q;
  logic             edge_det;
  logic             accept;

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign edge_det = s2_q & ~s3_q;

  // State register; async reset puts the FSM in IDLE so enb rises at once.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the shared down-counter times both MEAS and DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = (bus.win_len == '0) ? ST_DONE : ST_MEAS;
      ST_MEAS:  if (win_q == WIN_ONE) state_d = ST_DRAIN;
      ST_DRAIN: if (win_q == WIN_ONE) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drives enb high without a clock.
  always_comb begin
    bus.enb  = (state_q != ST_MEAS);
    bus.busy = (state_q == ST_MEAS) || (state_q == ST_DRAIN);
    bus.done = (state_q == ST_DONE);
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;

  // Window/drain counter and saturating edge counter next values.
  always_comb begin
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) win_d = bus.win_len;
      end
      ST_MEAS: begin
        win_d = (win_q == WIN_ONE) ? DRAIN_LEN : win_q - WIN_ONE;
      end
      ST_DRAIN: begin
        win_d = win_q - WIN_ONE;
      end
      default: ;
    endcase
    if (accept) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (((state_q == ST_MEAS) || (state_q == ST_DRAIN)) && edge_det) begin
      if (count_q == CNT_MAX) ovf_d = 1'b1;
      else                    count_d = count_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Two-flop synchronizer plus history flop; runs in every state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.cko_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

endmodule

// File: tb/tb_gated_osc_meter.sv
// Directed bench for gated_osc_meter: clk period 10, oscillator period 40
// (same 1:4 ratio as the 1 ns / 4 ns target), oscillator modelled as a
// free-running clock gated by the active-low enable (init value 0).
module tb_gated_osc_meter;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic osc_free;
  int   n_checks = 0;
  int   n_fail = 0;

  gated_osc_meter_if #(.CNT_W(16), .WIN_W(16)) m_if ();
  gated_osc_meter_if #(.CNT_W(4),  .WIN_W(16)) s_if ();

  gated_osc_meter #(.CNT_W(16), .WIN_W(16), .DRAIN(3)) u_dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (m_if.slave)
  );

  gated_osc_meter #(.CNT_W(4), .WIN_W(16), .DRAIN(3)) u_sat (
    .clk  (clk),
    .rstb (rstb),
    .bus  (s_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    osc_free = 1'b0;
    #3;
    forever #20 osc_free = ~osc_free;
  end

  assign m_if.cko_in = ~m_if.enb & osc_free;
  assign s_if.cko_in = ~s_if.enb & osc_free;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One measurement on the main instance; restart_at > 1 re-pulses start
  // that many cycles after T0. Sample i is taken in the cycle after edge T0+i-1.
  task automatic run_meas(input int win, input int restart_at,
                          output int done_k, output int enb_low, output int n_done,
                          output int busy_cyc, output logic [15:0] cnt, output logic ov);
    done_k = -1; enb_low = 0; n_done = 0; busy_cyc = 0; cnt = '1; ov = 1'bx;
    @(negedge clk);
    m_if.start   = 1'b1;
    m_if.win_len = win[15:0];
    for (int i = 1; i <= win + 40; i++) begin
      @(negedge clk);
      if (i == 1) m_if.start = 1'b0;
      if (i == restart_at) m_if.start = 1'b1;
      if (i == restart_at + 1) m_if.start = 1'b0;
      if (m_if.enb === 1'b0) enb_low++;
      if (m_if.busy === 1'b1) busy_cyc++;
      if (m_if.done === 1'b1) begin
        n_done++;
        if (done_k < 0) begin
          done_k = i - 1;
          cnt    = m_if.count;
          ov     = m_if.ovf;
        end
      end
    end
  endtask

  initial begin
    int         done_k, enb_low, n_done, busy_cyc, k;
    logic [15:0] cnt;
    logic       ov;

    m_if.start = 1'b0; m_if.win_len = '0;
    s_if.start = 1'b0; s_if.win_len = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_enb",   32'(m_if.enb),   32'd1);
    check("rst_busy",  32'(m_if.busy),  32'd0);
    check("rst_done",  32'(m_if.done),  32'd0);
    check("rst_count", 32'(m_if.count), 32'd0);
    check("rst_ovf",   32'(m_if.ovf),   32'd0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal 100-cycle window
    run_meas(100, 0, done_k, enb_low, n_done, busy_cyc, cnt, ov);
    check("nom_done_k",   32'(done_k),   32'd103);
    check("nom_enb_low",  32'(enb_low),  32'd100);
    check("nom_n_done",   32'(n_done),   32'd1);
    check("nom_busy_cyc", 32'(busy_cyc), 32'd103);
    check("nom_count_in_24_26", 32'(cnt >= 16'd24 && cnt <= 16'd26), 32'd1);
    check("nom_ovf",      32'(ov),       32'd0);

    // Zero-length window
    run_meas(0, 0, done_k, enb_low, n_done, busy_cyc, cnt, ov);
    check("zero_done_k",   32'(done_k),   32'd0);
    check("zero_enb_low",  32'(enb_low),  32'd0);
    check("zero_busy_cyc", 32'(busy_cyc), 32'd0);
    check("zero_n_done",   32'(n_done),   32'd1);
    check("zero_count",    32'(cnt),      32'd0);

    // Start pulse while busy is ignored
    run_meas(100, 21, done_k, enb_low, n_done, busy_cyc, cnt, ov);
    check("busy_start_n_done",  32'(n_done),  32'd1);
    check("busy_start_enb_low", 32'(enb_low), 32'd100);
    check("busy_start_done_k",  32'(done_k),  32'd103);

    // Reset in the middle of the window
    @(negedge clk);
    m_if.start = 1'b1; m_if.win_len = 16'd100;
    @(negedge clk);
    m_if.start = 1'b0;
    repeat (49) @(negedge clk);
    check("mid_meas_enb_low", 32'(m_if.enb), 32'd0);
    #1 rstb = 1'b0;
    #1;
    check("async_rst_enb",   32'(m_if.enb),   32'd1);
    check("async_rst_busy",  32'(m_if.busy),  32'd0);
    check("async_rst_done",  32'(m_if.done),  32'd0);
    check("async_rst_count", 32'(m_if.count), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    run_meas(100, 0, done_k, enb_low, n_done, busy_cyc, cnt, ov);
    check("post_rst_done_k",  32'(done_k),  32'd103);
    check("post_rst_enb_low", 32'(enb_low), 32'd100);
    check("post_rst_count_in_24_26", 32'(cnt >= 16'd24 && cnt <= 16'd26), 32'd1);

    // Saturation on the 4-bit instance: ~50 edges in a 200-cycle window
    n_done = 0; cnt = '0; ov = 1'b0;
    @(negedge clk);
    s_if.start = 1'b1; s_if.win_len = 16'd200;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (i == 1) s_if.start = 1'b0;
      if (s_if.done === 1'b1) begin
        if (n_done == 0) begin
          cnt = 16'(s_if.count);
          ov  = s_if.ovf;
        end
        n_done++;
      end
    end
    check("sat_count",  32'(cnt),    32'd15);
    check("sat_ovf",    32'(ov),     32'd1);
    check("sat_n_done", 32'(n_done), 32'd1);

    // Back-to-back with start held high
    @(negedge clk);
    m_if.win_len = 16'd10;
    m_if.start   = 1'b1;
    for (int m = 0; m < 3; m++) begin
      k = 0;
      while (m_if.done !== 1'b1 && k < 30) begin
        @(negedge clk);
        k++;
      end
      check("b2b_done_seen", 32'(m_if.done), 32'd1);
      check("b2b_count_in_2_4", 32'(m_if.count >= 16'd2 && m_if.count <= 16'd4), 32'd1);
      @(negedge clk);
      check("b2b_idle_enb",  32'(m_if.enb),  32'd1);
      check("b2b_idle_busy", 32'(m_if.busy), 32'd0);
      @(negedge clk);
      check("b2b_enb_fall",  32'(m_if.enb),  32'd0);
    end
    m_if.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
